// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronizes the lines, decodes Gray-code steps into
// cw/ccw pulses, a wrapping signed position and a sticky error flag.
// Optional per-line glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quadrature_decoder #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          A,
  input  logic                          B,
  input  logic                          clear,
  input  logic                          error_clr,
  output logic signed [COUNT_WIDTH-1:0] position,
  output logic                          step_cw,
  output logic                          step_ccw,
  output logic                          direction,
  output logic                          error,
  output logic                          o_dbg_state
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // INIT lasts until the reset zeros have drained out of the input pipeline,
  // so a nonzero resting level is absorbed instead of looking like a jump.
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int INIT_CYCLES = SYNC_STAGES + FILTER_LEN + 1;
`else
  localparam int INIT_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  if (COUNT_WIDTH < 2 || SYNC_STAGES < 2 || FILTER_LEN < 2) begin : g_param_check
    $error("quadrature_decoder: COUNT_WIDTH, SYNC_STAGES and FILTER_LEN must be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             w_sync;
  logic [1:0]             w_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], A};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], B};
    end
  end

  assign w_sync = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       r_filt;
  logic [FLT_W-1:0] r_flt_cnt [2];

  // A line only moves once the raw value has disagreed for FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_filt[i]) begin
          r_flt_cnt[i] <= '0;
        end else if (r_flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          r_filt[i]    <= w_sync[i];
          r_flt_cnt[i] <= '0;
        end else begin
          r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = w_sync;
`endif

  function automatic logic [1:0] cw_after(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_after(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  state_t                 r_state, w_state_next;
  logic [1:0]             r_prev, w_prev_next;
  logic [INIT_W-1:0]      r_init_cnt, w_init_cnt_next;
  logic [COUNT_WIDTH-1:0] r_position, w_position_next;
  logic                   r_step_cw, w_step_cw_next;
  logic                   r_step_ccw, w_step_ccw_next;
  logic                   r_direction, w_direction_next;
  logic                   r_error, w_error_next;
  logic                   w_is_cw, w_is_ccw, w_is_illegal;

  assign w_is_cw      = (w_s == cw_after(r_prev));
  assign w_is_ccw     = (w_s == ccw_after(r_prev));
  assign w_is_illegal = ((w_s ^ r_prev) == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_prev      <= 2'b00;
      r_init_cnt  <= '0;
      r_position  <= '0;
      r_step_cw   <= 1'b0;
      r_step_ccw  <= 1'b0;
      r_direction <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= w_prev_next;
      r_init_cnt  <= w_init_cnt_next;
      r_position  <= w_position_next;
      r_step_cw   <= w_step_cw_next;
      r_step_ccw  <= w_step_ccw_next;
      r_direction <= w_direction_next;
      r_error     <= w_error_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = w_s;
    w_init_cnt_next  = r_init_cnt;
    w_position_next  = r_position;
    w_step_cw_next   = 1'b0;
    w_step_ccw_next  = 1'b0;
    w_direction_next = r_direction;
    w_error_next     = error_clr ? 1'b0 : r_error;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          w_state_next = ST_TRACK;
        end else begin
          w_init_cnt_next = r_init_cnt + 1'b1;
        end
      end
      ST_TRACK: begin
        if (w_s == r_prev) begin
          w_prev_next = r_prev;
        end else if (w_is_cw) begin
          w_step_cw_next   = 1'b1;
          w_position_next  = r_position + COUNT_WIDTH'(1);
          w_direction_next = 1'b1;
        end else if (w_is_ccw) begin
          w_step_ccw_next  = 1'b1;
          w_position_next  = r_position - COUNT_WIDTH'(1);
          w_direction_next = 1'b0;
        end else if (w_is_illegal) begin
          w_error_next = 1'b1;
        end
      end
      default: w_state_next = ST_INIT;
    endcase
    // Clear wins over a same-cycle step; the pulse and direction still report it.
    if (clear) w_position_next = '0;
  end

  assign position    = r_position;
  assign step_cw     = r_step_cw;
  assign step_ccw    = r_step_ccw;
  assign direction   = r_direction;
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a 16-bit instance with a position
// scoreboard plus a 4-bit instance for wrap checks, sharing the same inputs.
module tb_quadrature_decoder;

  localparam int SYNC = 2;
  localparam int FL   = 4;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FL;
`else
  localparam int LAT = SYNC;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        A, B, clear, error_clr;
  logic [15:0] position;
  logic        step_cw, step_ccw, direction, error, dbg_state;
  logic [3:0]  position4;
  logic        step_cw4, step_ccw4, direction4, error4, dbg_state4;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_cw  = 0;
  int cnt_ccw = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  quadrature_decoder #(.COUNT_WIDTH(16), .SYNC_STAGES(SYNC), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clear(clear), .error_clr(error_clr),
    .position(position), .step_cw(step_cw), .step_ccw(step_ccw),
    .direction(direction), .error(error), .o_dbg_state(dbg_state)
  );

  quadrature_decoder #(.COUNT_WIDTH(4), .SYNC_STAGES(SYNC), .FILTER_LEN(FL)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .clear(clear), .error_clr(error_clr),
    .position(position4), .step_cw(step_cw4), .step_ccw(step_ccw4),
    .direction(direction4), .error(error4), .o_dbg_state(dbg_state4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks; always entered and left on a falling edge
  task automatic drive(input logic a, input logic b, input int hold);
    A = a;
    B = b;
    repeat (hold) @(negedge clk);
  endtask

  task automatic meas_lat(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (step_cw) break;
    end
  endtask

  // scoreboard: every step pulse must match the next expected position
  always @(negedge clk) begin
    if (rst_n && (step_cw || step_ccw)) begin
      check("pulse_excl", {31'd0, step_cw & step_ccw}, 32'd0);
      check("step_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("pos_on_step", {16'd0, position}, {16'd0, exp_q.pop_front()});
      if (step_cw) cnt_cw++;
      if (step_ccw) cnt_ccw++;
    end
  end

  initial begin
    int snap_cw, snap_ccw, lat;
    rst_n = 1'b0; A = 1'b0; B = 1'b0; clear = 1'b0; error_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_position", {16'd0, position}, 32'd0);
    check("rst_step", {30'd0, step_cw, step_ccw}, 32'd0);
    check("rst_dir_err", {30'd0, direction, error}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_init_state", {31'd0, dbg_state}, 32'd1);
    check("post_init_pos", {16'd0, position}, 32'd0);

    // four clockwise steps
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
    drive(1, 0, 8); drive(1, 1, 8); drive(0, 1, 8); drive(0, 0, 8);
    check("cw_count", cnt_cw, 4);
    check("cw_position", {16'd0, position}, 32'd4);
    check("cw_direction", {31'd0, direction}, 32'd1);
    check("cw_error", {31'd0, error}, 32'd0);
    check("cw_pos4", {28'd0, position4}, 32'd4);

    // drive the 4-bit instance to +7, then across the wrap
    for (int i = 5; i <= 8; i++) exp_q.push_back(16'(i));
    drive(1, 0, 8); drive(1, 1, 8); drive(0, 1, 8);
    check("pos4_at_7", {28'd0, position4}, 32'd7);
    drive(0, 0, 8);
    check("pos4_wrap", {28'd0, position4}, 32'h8);
    check("pos16_at_8", {16'd0, position}, 32'd8);

    // clear coinciding with a clockwise step
    exp_q.push_back(16'd0);
    A = 1'b1; B = 1'b0;
    repeat (LAT) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_step_pulse", {31'd0, step_cw}, 32'd1);
    check("clr_step_pos", {16'd0, position}, 32'd0);
    check("clr_step_pos4", {28'd0, position4}, 32'd0);
    repeat (6) @(negedge clk);

    // back to 00 (one ccw step), then a plain clear
    exp_q.push_back(16'hFFFF);
    drive(0, 0, 8);
    check("ccw_single_pos", {16'd0, position}, 32'hFFFF);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("clear_pos", {16'd0, position}, 32'd0);

    // six counter-clockwise steps from zero
    snap_ccw = cnt_ccw;
    for (int i = 1; i <= 6; i++) exp_q.push_back(16'(-i));
    drive(0, 1, 8); drive(1, 1, 8); drive(1, 0, 8);
    drive(0, 0, 8); drive(0, 1, 8); drive(1, 1, 8);
    check("ccw_count", cnt_ccw - snap_ccw, 6);
    check("ccw_position", {16'd0, position}, 32'hFFFA);
    check("ccw_direction", {31'd0, direction}, 32'd0);
    check("ccw_pos4", {28'd0, position4}, 32'hA);

    // illegal jump 11 -> 00
    snap_cw = cnt_cw; snap_ccw = cnt_ccw;
    A = 1'b0; B = 1'b0;
    repeat (LAT) @(negedge clk);
    check("err_not_yet", {31'd0, error}, 32'd0);
    @(negedge clk);
    check("err_set", {31'd0, error}, 32'd1);
    repeat (4) @(negedge clk);
    check("err_pos_hold", {16'd0, position}, 32'hFFFA);
    check("err_no_pulse", (cnt_cw - snap_cw) + (cnt_ccw - snap_ccw), 0);
    check("err_dir_hold", {31'd0, direction}, 32'd0);
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    check("err_cleared", {31'd0, error}, 32'd0);

    // error_clr in the same cycle as a new illegal jump 00 -> 11
    A = 1'b1; B = 1'b1;
    repeat (LAT) @(negedge clk);
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    check("err_clr_collide", {31'd0, error}, 32'd1);
    repeat (2) @(negedge clk);
    check("err_sticky", {31'd0, error}, 32'd1);
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    check("err_cleared2", {31'd0, error}, 32'd0);

    // reset mid-operation with AB held at 11
    snap_cw = cnt_cw; snap_ccw = cnt_ccw;
    rst_n = 1'b0;
    #1;
    check("async_rst_pos", {16'd0, position}, 32'd0);
    check("async_rst_state", {31'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rest11_no_pulse", (cnt_cw - snap_cw) + (cnt_ccw - snap_ccw), 0);
    check("rest11_no_err", {31'd0, error}, 32'd0);
    check("rest11_pos", {16'd0, position}, 32'd0);
    exp_q.push_back(16'd1);
    drive(0, 1, 8);
    check("rest11_step_pos", {16'd0, position}, 32'd1);
    check("rest11_step_dir", {31'd0, direction}, 32'd1);

    // pipeline latency of a clockwise step 01 -> 00
    exp_q.push_back(16'd2);
    A = 1'b0; B = 1'b0;
    meas_lat(lat);
    check("latency_01_00", lat, LAT + 1);
    repeat (8) @(negedge clk);

`ifdef QDEC_GLITCH_FILTER_EN
    // a 2-cycle bounce on A is swallowed; a held edge steps after SYNC+FL
    snap_cw = cnt_cw;
    A = 1'b1;
    repeat (2) @(negedge clk);
    A = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_no_step", cnt_cw - snap_cw, 0);
    check("glitch_pos", {16'd0, position}, 32'd2);
    exp_q.push_back(16'd3);
    A = 1'b1;
    meas_lat(lat);
    check("filter_latency", lat, SYNC + FL + 1);
    repeat (8) @(negedge clk);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
